ebus_diag_arbiter: RTL and testbench

//  Shares the EBUS diagnostic port between N_REQ front-end requesters (DTE request queue, console, self-test).

---
 rtl/kl10_dte_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/ebus_diag_arbiter.sv | 155 +++++++++++++++
 tb/tb_ebus_diag_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kl10_dte_pkg.sv
// Shared DTE front-end types: request kinds, misc codes,
// EBUS diag widths and the diag arbiter transaction bundle.
package kl10_dte_pkg;

  localparam int DS_W   = 7;
  localparam int EBUS_W = 36;

  typedef enum logic [1:0] {
    feFunc  = 2'd0,
    feRead  = 2'd1,
    feWrite = 2'd2,
    feMisc  = 2'd3
  } tFEReqType;

  typedef enum logic [DS_W-1:0] {
    clrCROBAR = 7'd0
  } tMiscFuncType;

  typedef enum logic [2:0] {
    sIdle,
    sSetup,
    sStrobe,
    sSettle,
    sResp
  } tDiagState;

  typedef struct packed {
    tFEReqType         typ;
    logic [DS_W-1:0]   ds;
    logic [EBUS_W-1:0] data;
  } tDiagTxn;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int   k;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (en && !found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/ebus_diag_arbiter.sv
// EBUS diagnostic port sharer: round-robin grant, then a
// SETUP/STROBE/SETTLE bus cycle (or a direct misc op) and one reply.
module ebus_diag_arbiter
  import kl10_dte_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 3,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [2*N_REQ-1:0]      req_type,
  input  logic [DS_W*N_REQ-1:0]   req_ds,
  input  logic [EBUS_W*N_REQ-1:0] req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IW-1:0]           rsp_id,
  output logic [EBUS_W-1:0]       rsp_data,
  output logic [DS_W-1:0]         ebus_ds,
  output logic                    ebus_diag_strobe,
  output logic                    ebus_drive,
  output logic [EBUS_W-1:0]       ebus_data_out,
  input  logic [EBUS_W-1:0]       ebus_data_in,
  output logic                    crobar_clr
);

  localparam int MAXP_A = (SETUP_CYCLES > STROBE_CYCLES) ?
                          SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAXP   = (MAXP_A > SETTLE_CYCLES) ?
                          MAXP_A : SETTLE_CYCLES;
  localparam int CW     = $clog2(MAXP) + 1;

  tDiagState         state, stateNxt;
  logic [CW-1:0]     cnt, cntNxt;
  logic [N_REQ-1:0]  grantVec;
  logic [IW-1:0]     grantIdx, rrPtr, ptrNxt, txnId;
  logic              anyGrant;
  tDiagTxn           reqTxn, txn;
  logic [EBUS_W-1:0] rdData;
  logic              crobarQ;
  logic              busCyc, showDs;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req   (req_valid),
    .en    (state == sIdle),
    .ptr   (rrPtr),
    .grant (grantVec),
    .idx   (grantIdx)
  );

  assign anyGrant  = |grantVec;
  assign req_ready = grantVec;

  always_comb begin
    reqTxn.typ  = tFEReqType'(req_type[2*int'(grantIdx) +: 2]);
    reqTxn.ds   = req_ds[DS_W*int'(grantIdx) +: DS_W];
    reqTxn.data = req_data[EBUS_W*int'(grantIdx) +: EBUS_W];
  end

  assign ptrNxt = (int'(grantIdx) == N_REQ - 1) ?
                  '0 : grantIdx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= sIdle;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    unique case (state)
      sIdle: begin
        if (anyGrant) begin
          stateNxt = (reqTxn.typ == feMisc) ? sResp : sSetup;
          cntNxt   = CW'(SETUP_CYCLES - 1);
        end
      end
      sSetup: begin
        if (cnt == '0) begin
          stateNxt = sStrobe;
          cntNxt   = CW'(STROBE_CYCLES - 1);
        end else begin
          cntNxt = cnt - 1'b1;
        end
      end
      sStrobe: begin
        if (cnt == '0) begin
          stateNxt = sSettle;
          cntNxt   = CW'(SETTLE_CYCLES - 1);
        end else begin
          cntNxt = cnt - 1'b1;
        end
      end
      sSettle: begin
        if (cnt == '0) stateNxt = sResp;
        else           cntNxt   = cnt - 1'b1;
      end
      sResp: begin
        if (rsp_ready) stateNxt = sIdle;
      end
      default: stateNxt = sIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn     <= '0;
      txnId   <= '0;
      rrPtr   <= '0;
      rdData  <= '0;
      crobarQ <= 1'b0;
    end else begin
      crobarQ <= 1'b0;
      if (anyGrant) begin
        txn     <= reqTxn;
        txnId   <= grantIdx;
        rrPtr   <= ptrNxt;
        rdData  <= '0;
        crobarQ <= (reqTxn.typ == feMisc) &&
                   (reqTxn.ds == clrCROBAR);
      end else if (state == sSettle && cnt == '0 &&
                   txn.typ == feRead) begin
        rdData <= ebus_data_in;
      end
    end
  end

  // Misc ops never touch the bus, so ds stays parked at 0 for them.
  assign busCyc = (state == sSetup) || (state == sStrobe) ||
                  (state == sSettle);
  assign showDs = busCyc ||
                  (state == sResp && txn.typ != feMisc);

  assign ebus_ds          = showDs ? txn.ds : '0;
  assign ebus_diag_strobe = (state == sStrobe);
  assign ebus_drive       = busCyc && (txn.typ == feWrite);
  assign ebus_data_out    = ebus_drive ? txn.data : '0;
  assign rsp_valid        = (state == sResp);
  assign rsp_id           = txnId;
  assign rsp_data         = rdData;
  assign crobar_clr       = crobarQ;

endmodule

// File: tb/tb_ebus_diag_arbiter.sv
// Bench for ebus_diag_arbiter: timeline model of each transaction,
// random traffic plus directed bus-cycle, misc, backpressure, reset.
module tb_ebus_diag_arbiter;

  localparam int N  = 2;
  localparam int S  = 1;
  localparam int ST = 2;
  localparam int SE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [2*N-1:0]  req_type = '0;
  logic [7*N-1:0]  req_ds = '0;
  logic [36*N-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_id;
  logic [35:0]   rsp_data;
  logic [6:0]    ebus_ds;
  logic          ebus_diag_strobe;
  logic          ebus_drive;
  logic [35:0]   ebus_data_out;
  logic [35:0]   ebus_data_in = '0;
  logic          crobar_clr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [N-1:0] gr;

  ebus_diag_arbiter #(
    .N_REQ(N), .SETUP_CYCLES(S),
    .STROBE_CYCLES(ST), .SETTLE_CYCLES(SE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_ds(req_ds), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .ebus_ds(ebus_ds), .ebus_diag_strobe(ebus_diag_strobe),
    .ebus_drive(ebus_drive), .ebus_data_out(ebus_data_out),
    .ebus_data_in(ebus_data_in), .crobar_clr(crobar_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  // Model: one transaction at a time, phase derived from the
  // number of cycles elapsed since its grant.
  bit          mBusy = 1'b0;
  int          mE = 0;
  int          mPtr = 0;
  int          mId = 0;
  logic [1:0]  mTyp = '0;
  logic [6:0]  mDs = '0;
  logic [35:0] mData = '0;
  logic [35:0] mRd = '0;

  function automatic int arb();
    for (int i = 0; i < N; i++)
      if (req_valid[(mPtr + i) % N]) return (mPtr + i) % N;
    return -1;
  endfunction

  function automatic int respE(input logic [1:0] t);
    return (t == 2'd3) ? 1 : 1 + S + ST + SE;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    int g;
    if (!rst_n) begin
      mBusy <= 1'b0;
      mE    <= 0;
      mPtr  <= 0;
      mId   <= 0;
      mRd   <= '0;
    end else if (mBusy) begin
      if (mE >= respE(mTyp) && rsp_ready) begin
        mBusy <= 1'b0;
      end else begin
        if (mTyp == 2'd1 && mE == S + ST + SE) mRd <= ebus_data_in;
        mE <= mE + 1;
      end
    end else begin
      g = arb();
      if (g >= 0) begin
        mBusy <= 1'b1;
        mE    <= 1;
        mId   <= g;
        mPtr  <= (g + 1) % N;
        mRd   <= '0;
        mTyp  <= req_type[2*g +: 2];
        mDs   <= req_ds[7*g +: 7];
        mData <= req_data[36*g +: 36];
      end
    end
  end

  always @(negedge clk) begin : cmp
    int g;
    bit misc, stup, strb, stl, rsp;
    logic [N-1:0] eRdy;
    #1;
    eRdy = '0;
    misc = 0; stup = 0; strb = 0; stl = 0; rsp = 0;
    if (!mBusy) begin
      g = arb();
      if (g >= 0) eRdy[g] = 1'b1;
    end else begin
      misc = (mTyp == 2'd3);
      stup = !misc && mE >= 1 && mE <= S;
      strb = !misc && mE > S && mE <= S + ST;
      stl  = !misc && mE > S + ST && mE <= S + ST + SE;
      rsp  = mE >= respE(mTyp);
    end
    chk("req_ready", 64'(req_ready), 64'(eRdy));
    chk("ebus_ds", 64'(ebus_ds),
        64'((!misc && (stup || strb || stl || rsp)) ? mDs : 7'd0));
    chk("strobe", 64'(ebus_diag_strobe), 64'(strb));
    chk("drive", 64'(ebus_drive),
        64'((stup || strb || stl) && mTyp == 2'd2));
    chk("data_out", 64'(ebus_data_out),
        64'(((stup || strb || stl) && mTyp == 2'd2) ? mData : 36'd0));
    chk("rsp_valid", 64'(rsp_valid), 64'(rsp));
    chk("crobar", 64'(crobar_clr),
        64'(mBusy && misc && mDs == 7'd0 && mE == 1));
    if (rsp) begin
      chk("rsp_id", 64'(rsp_id), 64'(mId));
      chk("rsp_data", 64'(rsp_data), 64'(mRd));
    end
  end

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
    #2;
  endtask

  task automatic issue(input int r, input logic [1:0] ty,
                       input logic [6:0] ds, input logic [35:0] d,
                       output int gc);
    @(negedge clk);
    req_type[2*r +: 2]  = ty;
    req_ds[7*r +: 7]    = ds;
    req_data[36*r +: 36] = d;
    req_valid[r] = 1'b1;
    gc = -1;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (req_ready[r]) begin
        gc = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (gc < 0) begin
      failures++;
      $display("FAIL issue_timeout req=%0d actual=no_grant required=grant", r);
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask

  initial begin : stim
    int t, last, cnt;
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_strobe", 64'(ebus_diag_strobe), 64'd0);
    chk("rst_drive", 64'(ebus_drive), 64'd0);
    chk("rst_ds", 64'(ebus_ds), 64'd0);
    chk("rst_crobar", 64'(crobar_clr), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write on req0
    issue(0, 2'd2, 7'h0A, 36'h123456789, t);
    at(t + 1);
    chk("wr_ds", 64'(ebus_ds), 64'h0A);
    chk("wr_drive", 64'(ebus_drive), 64'd1);
    chk("wr_data", 64'(ebus_data_out), 64'h123456789);
    chk("wr_strobe_setup", 64'(ebus_diag_strobe), 64'd0);
    at(t + 2);
    chk("wr_strobe_t2", 64'(ebus_diag_strobe), 64'd1);
    at(t + 3);
    chk("wr_strobe_t3", 64'(ebus_diag_strobe), 64'd1);
    at(t + 4);
    chk("wr_strobe_t4", 64'(ebus_diag_strobe), 64'd0);
    at(t + 6);
    chk("wr_rsp_early", 64'(rsp_valid), 64'd0);
    at(t + 7);
    chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_rsp_data", 64'(rsp_data), 64'd0);

    // Read on req1
    ebus_data_in = 36'hFEDCBA987;
    issue(1, 2'd1, 7'h71, 36'h0, t);
    for (int e = 1; e <= 7; e++) begin
      at(t + e);
      chk("rd_no_drive", 64'(ebus_drive), 64'd0);
    end
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_data", 64'(rsp_data), 64'hFEDCBA987);
    chk("rd_rsp_id", 64'(rsp_id), 64'd1);

    // Misc clrCROBAR then misc code 5
    issue(1, 2'd3, 7'd0, 36'h0, t);
    at(t + 1);
    chk("misc0_crobar", 64'(crobar_clr), 64'd1);
    chk("misc0_rsp", 64'(rsp_valid), 64'd1);
    chk("misc0_strobe", 64'(ebus_diag_strobe), 64'd0);
    at(t + 2);
    chk("misc0_pulse_end", 64'(crobar_clr), 64'd0);
    issue(0, 2'd3, 7'd5, 36'h0, t);
    at(t + 1);
    chk("misc5_crobar", 64'(crobar_clr), 64'd0);
    chk("misc5_rsp", 64'(rsp_valid), 64'd1);
    chk("misc5_data", 64'(rsp_data), 64'd0);

    // Backpressure
    @(negedge clk);
    rsp_ready = 1'b0;
    ebus_data_in = 36'h0000ABCDE;
    issue(0, 2'd1, 7'h33, 36'h0, t);
    at(t + 7);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      at(t + 7 + i);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_data", 64'(rsp_data), 64'h0000ABCDE);
      chk("bp_rsp_id", 64'(rsp_id), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid[1] = 1'b0;

    // Alternation with both requesters held valid
    @(negedge clk);
    req_type = '0;
    req_valid = 2'b11;
    last = -1;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 6; i++) begin
      #2;
      if (req_ready != '0) begin
        if (last >= 0)
          chk("rr_alternate", 64'(req_ready[0] ? 0 : 1),
              64'(1 - last));
        last = req_ready[0] ? 0 : 1;
        cnt++;
      end
      @(negedge clk);
    end
    checks++;
    if (cnt < 6) begin
      failures++;
      $display("FAIL rr_grants actual=%0d required=6", cnt);
    end
    req_valid = '0;

    // Async reset during strobe of a write
    issue(1, 2'd2, 7'h15, 36'h55AA55AA5, t);
    at(t + 2);
    chk("rstw_strobe_pre", 64'(ebus_diag_strobe), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_strobe", 64'(ebus_diag_strobe), 64'd0);
    chk("rstw_drive", 64'(ebus_drive), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      at(t + 4 + i);
      chk("rstw_no_rsp", 64'(rsp_valid), 64'd0);
    end
    issue(0, 2'd2, 7'h22, 36'h0F0F0F0F0, t);
    at(t + 7);
    chk("rstw_next_rsp", 64'(rsp_valid), 64'd1);
    chk("rstw_next_id", 64'(rsp_id), 64'd0);

    // Random traffic
    gr = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (gr[r]) begin
          req_valid[r] = 1'b0;
        end else if (req_valid[r] && $urandom % 16 == 0) begin
          req_valid[r] = 1'b0;
        end else if (!req_valid[r] && $urandom % 3 == 0) begin
          req_type[2*r +: 2] = 2'($urandom);
          req_ds[7*r +: 7] = ($urandom % 2 == 0) ? 7'd0 : 7'($urandom);
          req_data[36*r +: 36] = {4'($urandom), 32'($urandom)};
          req_valid[r] = 1'b1;
        end
      end
      rsp_ready = ($urandom % 4) != 0;
      ebus_data_in = {4'($urandom), 32'($urandom)};
      #2;
      gr = req_ready;
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
